// File: rtl/video_timing_detect.sv
// Receive-side video timing detector: recovers pixel coordinates and frame/line pulses
// from hsync/vsync/de and measures frame timing, asserting locked once it is stable.
module video_timing_detect #(
  parameter int CW          = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          video_clk,
  input  logic          reset,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pixel_valid,
  output logic          framestart,
  output logic          linestart,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          locked,
  output logic          timing_err
);

  localparam int            MW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] MAX    = '1;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [MW-1:0] ONE_M  = MW'(1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  logic          hs_p1, vs_p1, de_p1, hs_p2, vs_p2, de_p2;
  logic          hs_rise, vs_rise, de_rise, de_fall;
  logic [CW-1:0] hcnt, de_cnt, line_total, line_active, line_cnt, act_cnt;
  logic          have_line, line_mismatch;
  logic [CW-1:0] line_total_c, line_active_c, line_cnt_c, act_cnt_c;
  logic          mismatch_c, same, wdog;
  state_t        state, state_n;
  logic [MW-1:0] match, match_n;
  logic          locked_n, err_n;

  // Stage 1 samples the inputs, stage 2 holds the previous sample for edge detection
  always_ff @(posedge video_clk) begin
    if (reset) begin
      {hs_p1, vs_p1, de_p1, hs_p2, vs_p2, de_p2} <= '0;
    end else begin
      {hs_p1, vs_p1, de_p1} <= {hsync_in, vsync_in, de_in};
      {hs_p2, vs_p2, de_p2} <= {hs_p1, vs_p1, de_p1};
    end
  end

  assign hs_rise = hs_p1 & ~hs_p2;
  assign vs_rise = vs_p1 & ~vs_p2;
  assign de_rise = de_p1 & ~de_p2;
  assign de_fall = ~de_p1 & de_p2;

  // Line-level results of this cycle, so a coincident vsync rise snapshots the closing line
  always_comb begin
    line_total_c = line_total;
    line_cnt_c   = line_cnt;
    mismatch_c   = line_mismatch;
    if (hs_rise) begin
      line_total_c = sat_inc(hcnt);
      line_cnt_c   = sat_inc(line_cnt);
      if (have_line && (line_total_c != line_total)) mismatch_c = 1'b1;
    end
    line_active_c = de_fall ? de_cnt : line_active;
    act_cnt_c     = de_fall ? sat_inc(act_cnt) : act_cnt;
  end

  assign same = !mismatch_c && (line_total_c == h_total) && (line_active_c == h_active) &&
                (line_cnt_c == v_total) && (act_cnt_c == v_active);
  assign wdog = (hcnt == MAX) || (line_cnt == MAX);

  // Measurement counters; the snapshot registers double as the previous-frame reference
  always_ff @(posedge video_clk) begin
    if (reset) begin
      {hcnt, de_cnt, line_total, line_active, line_cnt, act_cnt} <= '0;
      {h_total, h_active, v_total, v_active}                     <= '0;
      have_line     <= 1'b0;
      line_mismatch <= 1'b0;
    end else begin
      hcnt        <= hs_rise ? '0 : sat_inc(hcnt);
      de_cnt      <= de_rise ? ONE : (de_p1 ? sat_inc(de_cnt) : de_cnt);
      line_total  <= line_total_c;
      line_active <= line_active_c;
      if (vs_rise) begin
        line_cnt      <= '0;
        act_cnt       <= '0;
        line_mismatch <= 1'b0;
        have_line     <= 1'b0;
        h_total       <= line_total_c;
        h_active      <= line_active_c;
        v_total       <= line_cnt_c;
        v_active      <= act_cnt_c;
      end else begin
        line_cnt      <= line_cnt_c;
        act_cnt       <= act_cnt_c;
        line_mismatch <= mismatch_c;
        if (hs_rise) have_line <= 1'b1;
      end
    end
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      framestart  <= 1'b0;
      linestart   <= 1'b0;
    end else begin
      pixel_valid <= de_p1;
      linestart   <= de_rise;
      framestart  <= vs_rise;
      if (de_rise)    pixel_x <= '0;
      else if (de_p1) pixel_x <= pixel_x + ONE;
      if (vs_rise)      pixel_y <= '0;
      else if (de_fall) pixel_y <= pixel_y + ONE;
    end
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      state      <= SEARCH;
      match      <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_n;
      match      <= match_n;
      locked     <= locked_n;
      timing_err <= err_n;
    end
  end

  // The first frame after SEARCH is partial, so it only primes the reference
  always_comb begin
    state_n = state;
    match_n = match;
    if (wdog) begin
      state_n = SEARCH;
      match_n = '0;
    end else if (vs_rise) begin
      case (state)
        SEARCH: begin
          state_n = TRACK;
          match_n = '0;
        end
        TRACK: begin
          match_n = same ? match + ONE_M : '0;
          if (match_n == LOCK_M) state_n = LOCKED;
        end
        LOCKED: begin
          if (!same) begin
            state_n = TRACK;
            match_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_n = (state_n == LOCKED);
    err_n    = (state == LOCKED) && (state_n != LOCKED);
  end

endmodule

// File: tb/tb_video_timing_detect.sv
// Bench for video_timing_detect: random small video formats driven through lock, glitch,
// watchdog and mid-frame reset, compared cycle by cycle against an event-based model.
module tb_video_timing_detect;
  localparam int CW  = 12;
  localparam int HSW = 4;
  localparam int HS  = 6;
  localparam int VS  = 3;

  logic          video_clk = 1'b0;
  logic          reset = 1'b1;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
  logic [CW-1:0] pixel_x, pixel_y, h_total, h_active, v_total, v_active;
  logic          pixel_valid, framestart, linestart, locked, timing_err;

  video_timing_detect #(.CW(CW), .LOCK_FRAMES(2)) dut (
    .video_clk(video_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .framestart(framestart), .linestart(linestart), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked), .timing_err(timing_err)
  );

  always #5 video_clk = ~video_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    bit rst, valid, ls, fs, lk, err;
    int x, y, ht, ha, vt, va, rises;
  } exp_t;

  exp_t expq = '0;
  exp_t due  = '0;

  // Reference model: works on sample indices and event times of the input stream
  int n_cyc = 0;
  bit ph, pv, pd, have_line, mism, searching = 1'b1, lk;
  int last_rise, gap, lines, acts, line_act, run_start, yrow, match_cnt, rises;
  int snap[4];

  always @(posedge video_clk) begin
    bit hr, vr, dr, df, wd, same, err;
    int g;
    due = expq;
    if (reset) begin
      expq = '0; expq.rst = 1'b1;
      due  = expq;
      {ph, pv, pd, have_line, mism, lk} = '0;
      searching = 1'b1;
      last_rise = n_cyc - 1;
      {gap, lines, acts, line_act, run_start, yrow, match_cnt, rises} = '0;
      foreach (snap[i]) snap[i] = 0;
    end else begin
      hr = hsync_in && !ph; vr = vsync_in && !pv;
      dr = de_in && !pd;    df = !de_in && pd;
      wd = (n_cyc - last_rise >= 4096) || (lines >= 4095);
      if (hr) begin
        g = n_cyc - last_rise;
        if (g > 4095) g = 4095;
        if (have_line && g != gap) mism = 1'b1;
        gap = g; have_line = 1'b1; last_rise = n_cyc;
        if (lines < 4095) lines++;
      end
      if (dr) run_start = n_cyc;
      if (df) begin
        line_act = (n_cyc - run_start > 4095) ? 4095 : n_cyc - run_start;
        if (acts < 4095) acts++;
      end
      if (vr) yrow = 0;
      else if (df) yrow++;
      same = !mism && gap == snap[0] && line_act == snap[1] && lines == snap[2] && acts == snap[3];
      err = 1'b0;
      if (wd) begin
        err = lk; lk = 1'b0; searching = 1'b1; match_cnt = 0;
      end else if (vr) begin
        if (searching) begin
          searching = 1'b0; match_cnt = 0;
        end else if (lk) begin
          if (!same) begin lk = 1'b0; err = 1'b1; match_cnt = 0; end
        end else begin
          match_cnt = same ? match_cnt + 1 : 0;
          if (match_cnt >= 2) lk = 1'b1;
        end
      end
      if (vr) begin
        snap[0] = gap; snap[1] = line_act; snap[2] = lines; snap[3] = acts;
        lines = 0; acts = 0; mism = 1'b0; have_line = 1'b0; rises++;
      end
      expq.rst = 1'b0; expq.valid = de_in; expq.ls = dr; expq.fs = vr;
      expq.x = (n_cyc - run_start) % 4096; expq.y = yrow % 4096;
      expq.ht = snap[0]; expq.ha = snap[1]; expq.vt = snap[2]; expq.va = snap[3];
      expq.lk = lk; expq.err = err; expq.rises = rises;
      ph = hsync_in; pv = vsync_in; pd = de_in;
    end
    n_cyc++;
  end

  int err_pulses = 0;
  bit mon_prev_locked = 1'b0;
  bit mon_locked_since_rst = 1'b0;

  always @(negedge video_clk) begin
    check_val("pixel_valid", pixel_valid, due.valid);
    check_val("linestart", linestart, due.ls);
    check_val("framestart", framestart, due.fs);
    if (due.valid) begin
      check_val("pixel_x", pixel_x, due.x);
      check_val("pixel_y", pixel_y, due.y);
    end
    check_val("h_total", h_total, due.ht);
    check_val("h_active", h_active, due.ha);
    check_val("v_total", v_total, due.vt);
    check_val("v_active", v_active, due.va);
    check_val("locked", locked, due.lk);
    check_val("timing_err", timing_err, due.err);
    if (timing_err) err_pulses++;
    if (due.rst) mon_locked_since_rst = 1'b0;
    else if (locked && !mon_prev_locked && !mon_locked_since_rst) begin
      check_val("lock_vsync_rise_count", due.rises, 4);
      mon_locked_since_rst = 1'b1;
    end
    mon_prev_locked = locked;
  end

  task automatic run_frame(input int ht, input int ha, input int vt, input int va,
                           input int bad, input int rst_line);
    for (int l = 0; l < vt; l++) begin
      for (int c = 0; c < ((l == bad) ? ht + 1 : ht); c++) begin
        @(negedge video_clk);
        hsync_in = (c < HSW);
        vsync_in = (l < 2);
        de_in    = (l >= VS) && (l < VS + va) && (c >= HS) && (c < HS + ha);
        reset    = (l == rst_line) && (c == 10);
        if (reset) begin
          @(posedge video_clk); #1;
          check_val("rst_locked", locked, 0);
          check_val("rst_h_total", h_total, 0);
          check_val("rst_v_total", v_total, 0);
          check_val("rst_pixel_valid", pixel_valid, 0);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge video_clk);
      hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0; reset = 1'b0;
    end
  endtask

  task automatic check_format(input string tag, input int ht, input int ha, input int vt, input int va);
    check_val({tag, "_h_total"}, h_total, ht);
    check_val({tag, "_h_active"}, h_active, ha);
    check_val({tag, "_v_total"}, v_total, vt);
    check_val({tag, "_v_active"}, v_active, va);
  endtask

  initial begin
    int ht, ha, vt, va, e0;
    repeat (3) @(negedge video_clk);
    check_val("reset_locked", locked, 0);
    check_val("reset_h_total", h_total, 0);
    check_val("reset_framestart", framestart, 0);
    check_val("reset_pixel_x", pixel_x, 0);
    idle(20);

    ht = $urandom_range(40, 90); ha = $urandom_range(10, ht - 12);
    vt = $urandom_range(8, 18);  va = $urandom_range(3, vt - 3);
    repeat (5) run_frame(ht, ha, vt, va, -1, -1);
    check_val("lock_a", locked, 1);
    check_format("fmt_a", ht, ha, vt, va);

    e0 = err_pulses;
    run_frame(ht, ha, vt, va, $urandom_range(3, vt - 2), -1);
    run_frame(ht, ha, vt, va, -1, -1);
    check_val("glitch_err_pulses", err_pulses - e0, 1);
    check_val("glitch_unlocked", locked, 0);
    run_frame(ht, ha, vt, va, -1, -1);
    run_frame(ht, ha, vt, va, -1, -1);
    check_val("glitch_relock", locked, 1);

    e0 = err_pulses;
    idle(4200);
    check_val("wdog_err_pulses", err_pulses - e0, 1);
    check_val("wdog_unlocked", locked, 0);

    repeat (2) run_frame(ht, ha, vt, va, -1, -1);
    run_frame(ht, ha, vt, va, -1, vt / 2);
    repeat (5) run_frame(ht, ha, vt, va, -1, -1);
    check_val("rst_relock", locked, 1);
    check_format("fmt_a_rst", ht, ha, vt, va);

    ht = $urandom_range(30, 80); ha = $urandom_range(8, ht - 12);
    vt = $urandom_range(8, 16);  va = $urandom_range(3, vt - 3);
    repeat (6) run_frame(ht, ha, vt, va, -1, -1);
    check_val("lock_b", locked, 1);
    check_format("fmt_b", ht, ha, vt, va);

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
